// File: rtl/alu_pkg.sv
// Opcode encodings, FSM state type and latency constants shared by the
// alu_mdu execute-stage datapath and its iterative multiply/divide unit.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_LUI  = 4'b0001;
    localparam logic [3:0] OP_ORI  = 4'b0010;
    localparam logic [3:0] OP_SLLI = 4'b0011;
    localparam logic [3:0] OP_SRLI = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_REM  = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_BEQ  = 4'b1001;
    localparam logic [3:0] OP_BNE  = 4'b1010;
    localparam logic [3:0] OP_BLT  = 4'b1011;
    localparam logic [3:0] OP_BGE  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;
    localparam logic [3:0] OP_MULH = 4'b1110;
    localparam logic [3:0] OP_DIV  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam int LAT_SINGLE = 1;

    function automatic int LAT_MULTI(input int w);
        return w + 2;
    endfunction

    function automatic logic is_multi(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative magnitude datapath: shift-add multiplier and restoring divider
// sharing one accumulator/shift-register pair, one bit per step.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 step,
    input  logic                 div_op,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    output logic                 last,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] cnt;
    logic             div_mode;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic             fits;

    always_comb begin
        add_sum = {1'b0, acc} + (sreg[0] ? {1'b0, opnd} : '0);
        shifted = {acc, sreg[WIDTH-1]};
        fits    = shifted >= {1'b0, opnd};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CNT_W'(WIDTH - 1);
        end else if (step && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // NOTE: the datapath carries no reset; it is always reloaded by start
    // before its contents are consumed, which keeps the reset net small.
    always_ff @(posedge clk) begin
        if (start) begin
            div_mode <= div_op;
            acc      <= '0;
            sreg     <= div_op ? a_mag : b_mag;
            opnd     <= div_op ? b_mag : a_mag;
        end else if (step) begin
            if (div_mode) begin
                acc  <= fits ? WIDTH'(shifted - {1'b0, opnd}) : shifted[WIDTH-1:0];
                sreg <= {sreg[WIDTH-2:0], fits};
            end else begin
                acc  <= add_sum[WIDTH:1];
                sreg <= {add_sum[0], sreg[WIDTH-1:1]};
            end
        end
    end

    assign last      = (cnt == '0);
    assign product   = {acc, sreg};
    assign quotient  = sreg;
    assign remainder = acc;

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU: single-cycle integer ops plus multi-cycle MUL/MULH/DIV/REM
// behind a valid/ready handshake with a registered result.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [3:0]       ALU_Operation_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] ALU_Result_o,
    output logic             Zero_o
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state, state_nx;
    logic               accept, start, step, last;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   single_result, fix_result;
    logic [2*WIDTH-1:0] product, prod_s;
    logic [WIDTH-1:0]   quotient, remainder, quo_s, rem_s;
    logic               res_neg, div_zero, div_ovf;

    assign ready_o = (state == ST_IDLE);
    assign accept  = valid_i && ready_o;

    always_comb begin
        a_mag = A_i[WIDTH-1] ? -A_i : A_i;
        b_mag = B_i[WIDTH-1] ? -B_i : B_i;
    end

    // Branch ops return 0 when the condition holds, 1 otherwise.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case can leave it unassigned and infer a latch.
        single_result = '0;
        shamt         = B_i[SHAMT_W-1:0];
        case (ALU_Operation_i)
            OP_ADD:  single_result = A_i + B_i;
            OP_LUI:  single_result = B_i << 12;
            OP_ORI:  single_result = A_i | B_i;
            OP_SLLI: single_result = A_i << shamt;
            OP_SRLI: single_result = A_i >> shamt;
            OP_SUB:  single_result = A_i - B_i;
            OP_AND:  single_result = A_i & B_i;
            OP_XOR:  single_result = A_i ^ B_i;
            OP_BEQ:  single_result = {{(WIDTH-1){1'b0}}, A_i != B_i};
            OP_BNE:  single_result = {{(WIDTH-1){1'b0}}, A_i == B_i};
            OP_BLT:  single_result = {{(WIDTH-1){1'b0}}, !($signed(A_i) < $signed(B_i))};
            OP_BGE:  single_result = {{(WIDTH-1){1'b0}}, $signed(A_i) < $signed(B_i)};
            default: single_result = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        step     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && is_multi(ALU_Operation_i)) begin
                    start    = 1'b1;
                    state_nx = ST_ITER;
                end
            end
            ST_ITER: begin
                step = 1'b1;
                if (last) begin
                    state_nx = ST_FIX;
                end
            end
            ST_FIX:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .step      (step),
        .div_op    (is_div(ALU_Operation_i)),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .last      (last),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // Special cases override the iterated value so latency never depends on data.
    always_comb begin
        res_neg    = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        prod_s     = res_neg ? -product : product;
        quo_s      = res_neg ? -quotient : quotient;
        rem_s      = a_q[WIDTH-1] ? -remainder : remainder;
        div_zero   = (b_q == '0);
        div_ovf    = (a_q == MIN_VAL) && (b_q == '1);
        fix_result = '0;
        case (op_q)
            OP_MUL:  fix_result = prod_s[WIDTH-1:0];
            OP_MULH: fix_result = prod_s[2*WIDTH-1:WIDTH];
            OP_DIV:  fix_result = div_zero ? '1 : (div_ovf ? MIN_VAL : quo_s);
            OP_REM:  fix_result = div_zero ? a_q : (div_ovf ? '0 : rem_s);
            default: fix_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            valid_o      <= 1'b0;
            ALU_Result_o <= '0;
            Zero_o       <= 1'b1;
        end else begin
            state   <= state_nx;
            valid_o <= 1'b0;
            if (accept && !is_multi(ALU_Operation_i)) begin
                valid_o      <= 1'b1;
                ALU_Result_o <= single_result;
                Zero_o       <= (single_result == '0);
            end else if (state == ST_FIX) begin
                valid_o      <= 1'b1;
                ALU_Result_o <= fix_result;
                Zero_o       <= (fix_result == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            op_q <= ALU_Operation_i;
            a_q  <= A_i;
            b_q  <= B_i;
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed and randomized scoreboard bench for alu_mdu at WIDTH=32.
module tb_alu_mdu;

    localparam int W     = 32;
    localparam int LAT_S = 1;
    localparam int LAT_M = W + 2;

    localparam logic [3:0] ADD = 4'b0000, LUI = 4'b0001, ORI = 4'b0010, SLLI = 4'b0011;
    localparam logic [3:0] SRLI = 4'b0100, SUB = 4'b0101, REM = 4'b0110, AND_ = 4'b0111;
    localparam logic [3:0] XOR_ = 4'b1000, BEQ = 4'b1001, BNE = 4'b1010, BLT = 4'b1011;
    localparam logic [3:0] BGE = 4'b1100, MUL = 4'b1101, MULH = 4'b1110, DIV = 4'b1111;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] due;
        logic [31:0] id;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         valid_i = 1'b0;
    logic [3:0]   op = 4'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready_o, valid_o, zero_o;
    logic [W-1:0] res_o;

    exp_t         scoreboard[$];
    exp_t         ent;
    int           cyc = 0;
    int           next_id = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    logic [3:0]   rop;
    logic [31:0]  rx, ry;
    logic [3:0]   single_ops[12] = '{ADD, LUI, ORI, SLLI, SRLI, SUB, AND_, XOR_, BEQ, BNE, BLT, BGE};
    logic [3:0]   multi_ops[4]   = '{MUL, MULH, DIV, REM};

    alu_mdu #(.WIDTH(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .valid_i         (valid_i),
        .ALU_Operation_i (op),
        .A_i             (a),
        .B_i             (b),
        .ready_o         (ready_o),
        .valid_o         (valid_o),
        .ALU_Result_o    (res_o),
        .Zero_o          (zero_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx, sy;
        logic signed [63:0] p;
        logic [4:0]         sh;
        sx = x;
        sy = y;
        p  = sx * sy;
        sh = y[4:0];
        case (o)
            ADD:  return x + y;
            LUI:  return y << 12;
            ORI:  return x | y;
            SLLI: return x << sh;
            SRLI: return x >> sh;
            SUB:  return x - y;
            AND_: return x & y;
            XOR_: return x ^ y;
            BEQ:  return (x == y) ? 32'd0 : 32'd1;
            BNE:  return (x != y) ? 32'd0 : 32'd1;
            BLT:  return (sx < sy) ? 32'd0 : 32'd1;
            BGE:  return (sx >= sy) ? 32'd0 : 32'd1;
            MUL:  return p[31:0];
            MULH: return p[63:32];
            DIV:  begin
                if (y == 32'h0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
                return sx / sy;
            end
            default: begin
                if (y == 32'h0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
                return sx % sy;
            end
        endcase
    endfunction

    // Called at a falling edge; the request is accepted at the next rising edge.
    task automatic drive(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] e, input int lat);
        valid_i = 1'b1;
        op      = o;
        a       = x;
        b       = y;
        next_id++;
        scoreboard.push_back('{res: e, due: 32'(cyc + lat), id: 32'(next_id)});
    endtask

    task automatic run_multi(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] e, input logic hold);
        drive(o, x, y, e, LAT_M);
        for (int k = 1; k <= LAT_M; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (hold) begin
                    op = ADD;
                    a  = 32'd1;
                    b  = 32'd1;
                end else begin
                    valid_i = 1'b0;
                end
            end
            if (k == 1 || k == LAT_M - 1) check("ready_busy", 32'(ready_o), 32'd0);
            if (k == LAT_M) begin
                check("ready_again", 32'(ready_o), 32'd1);
                valid_i = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (scoreboard.size() != 0 && cyc > int'(scoreboard[0].due)) begin
            check($sformatf("missing_valid#%0d", scoreboard[0].id), 32'(cyc), scoreboard[0].due);
            void'(scoreboard.pop_front());
        end
        if (valid_o) begin
            if (scoreboard.size() == 0) begin
                check("spurious_valid", 32'(valid_o), 32'd0);
            end else begin
                ent = scoreboard.pop_front();
                check($sformatf("result#%0d", ent.id), res_o, ent.res);
                check($sformatf("zero#%0d", ent.id), 32'(zero_o), 32'(ent.res == 32'h0));
                check($sformatf("latency#%0d", ent.id), 32'(cyc), ent.due);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_result", res_o, 32'h0);
        check("rst_zero", 32'(zero_o), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        drive(ADD, 32'd5, 32'hFFFFFFFD, 32'd2, LAT_S);
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        drive(BEQ, 32'd7, 32'd7, 32'd0, LAT_S);
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);

        run_multi(MUL, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 1'b0);
        run_multi(MULH, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF, 1'b0);
        run_multi(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0);
        run_multi(REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0);
        run_multi(DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b0);
        run_multi(REM, 32'd5, 32'd0, 32'd5, 1'b0);
        run_multi(DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        run_multi(REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0);
        run_multi(DIV, 32'd100, 32'd7, 32'd14, 1'b1);

        // Back-to-back single-cycle ops starting in the previous valid_o cycle.
        drive(ADD, 32'd1, 32'd2, 32'd3, LAT_S);
        @(negedge clk);
        drive(XOR_, 32'hF0, 32'h3C, 32'hCC, LAT_S);
        @(negedge clk);
        drive(SLLI, 32'd1, 32'd35, 32'd8, LAT_S);
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            rop = single_ops[$urandom_range(0, 11)];
            rx  = $urandom;
            ry  = (i % 3 == 0) ? rx : $urandom;
            drive(rop, rx, ry, model(rop, rx, ry), LAT_S);
            @(negedge clk);
        end
        valid_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            rop = multi_ops[$urandom_range(0, 3)];
            rx  = $urandom;
            ry  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) - 32'd500 : $urandom;
            run_multi(rop, rx, ry, model(rop, rx, ry), 1'b0);
        end
        @(negedge clk);

        // Reset in cycle 10 of a DIV, with a competing request that reset must win.
        drive(DIV, 32'd100, 32'd3, 32'd33, LAT_M);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (9) @(negedge clk);
        void'(scoreboard.pop_back());
        reset   = 1'b1;
        valid_i = 1'b1;
        op      = ADD;
        a       = 32'd4;
        b       = 32'd4;
        @(negedge clk);
        check("abort_ready", 32'(ready_o), 32'd1);
        check("abort_valid", 32'(valid_o), 32'd0);
        check("abort_result", res_o, 32'h0);
        check("abort_zero", 32'(zero_o), 32'd1);
        reset   = 1'b0;
        valid_i = 1'b0;
        repeat (LAT_M + 6) @(negedge clk);

        check("scoreboard_empty", 32'(scoreboard.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, multi-cycle successor to the single-cycle datapath ALU. It keeps the existing 4-bit operation encoding, widens the datapath to `WIDTH`, and adds the RISC-V M-extension subset MUL/MULH/DIV/REM. The M-extension ops run on an iterative shift-add multiplier / restoring divider behind a valid/ready handshake. It sits in the execute stage: the control unit presents operands and operation, and the stall logic watches `ready_o`.

## Interface
- `WIDTH`, default 32: datapath width; must be ≥ 8 and a power of two.
- `SHAMT_W`, default $clog2(WIDTH): shift-amount bits taken from `B_i`.

Ports, in the order clock, reset, inputs, outputs:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `valid_i`, in, 1: operation request.
- `ALU_Operation_i`, in, 4: operation select.
- `A_i`, in, WIDTH: operand A, signed.
- `B_i`, in, WIDTH: operand B, signed.
- `ready_o`, out, 1: block can accept a request this cycle.
- `valid_o`, out, 1: one-cycle pulse marking `ALU_Result_o`/`Zero_o` as valid.
- `ALU_Result_o`, out, WIDTH: registered result.
- `Zero_o`, out, 1: registered, equals (`ALU_Result_o` == 0).

## Operation
- Encodings:
  - ADD 0000, LUI 0001, ORI 0010, SLLI 0011, SRLI 0100, SUB 0101, AND 0111, XOR 1000.
  - BEQ 1001, BNE 1010, BLT 1011, BGE 1100.
  - New: REM 0110, MUL 1101, MULH 1110, DIV 1111.
- A request is accepted when `valid_i && ready_o` at a rising edge. Operands and op are captured, so inputs may change afterwards.
- Single-cycle ops follow the existing semantics:
  - LUI = B<<12.
  - Shifts use `B_i[SHAMT_W-1:0]`; SRLI is a logical shift.
  - BLT/BGE compare signed.
  - Branch ops return 0 when the condition holds and 1 otherwise.
- Undefined encodings: result 0, `Zero_o` = 1, single-cycle latency.
- MUL returns the low WIDTH bits of signed A×B. MULH returns the high WIDTH bits of the signed 2·WIDTH product.
- DIV/REM are signed and truncate toward zero; the remainder takes the sign of the dividend.
- Special cases are forced in FIX, so the latency stays unchanged:
  - Divide by zero: DIV gives all ones, REM gives A.
  - Overflow (A = MIN, B = -1): DIV gives MIN, REM gives 0.
- Multi-cycle method: operands are converted to magnitudes, then iterated one bit per cycle for WIDTH cycles. FIX negates the result as the signs require.
- FSM:
  - IDLE: `ready_o` = 1.
    - Accepting a single-cycle op stays in IDLE and registers the result.
    - Accepting MUL/MULH/DIV/REM goes to ITER and loads counter = WIDTH-1.
  - ITER: one step per cycle; goes to FIX when counter = 0, otherwise decrements.
  - FIX: sign/special-case correction, then back to IDLE with `valid_o` set.
- `valid_i` while not in IDLE is ignored. Nothing is queued, and the requester must hold its request.
- There is no output backpressure. The consumer must take the result in the `valid_o` cycle.

## Timing
- Reset values: state IDLE, `ready_o` 1, `valid_o` 0, `ALU_Result_o` 0, `Zero_o` 1, counter 0.
- Cycle numbering: the request is accepted at the edge ending cycle 0.
- Single-cycle ops: `valid_o` is high in cycle 1 (latency 1).
- Multi-cycle ops:
  - ITER occupies cycles 1..WIDTH and FIX occupies cycle WIDTH+1.
  - `valid_o` is high in cycle WIDTH+2 (latency 34 at WIDTH=32).
  - `ready_o` is low in cycles 1..WIDTH+1 and high again in the `valid_o` cycle.
- Back-to-back: a request accepted in a `valid_o` cycle is legal. Single-cycle ops can therefore issue every cycle with `valid_o` held high continuously.
- `ALU_Result_o`/`Zero_o` hold their last value between `valid_o` pulses.
- Reset mid-operation: the next cycle shows reset values, and the aborted operation never produces `valid_o`.
- Reset has priority over an acceptance in the same cycle.

## Structure
- Package `alu_pkg`:
  - Opcode constants.
  - FSM state typedef (IDLE/ITER/FIX).
  - Latency constants `LAT_SINGLE` = 1 and `LAT_MULTI`(W) = W+2.
- Sub-module `mdu_iter`:
  - Holds the iterative magnitude multiplier/divider datapath: accumulator, shift register, counter.
  - Controls are start/step/op; outputs are the raw quotient/remainder/product.
  - Sign fixup, special cases, FSM and output registers stay in `alu_mdu`.

## Test plan
- ADD A=5, B=-3 → cycle 1: `valid_o`=1, result 2, `Zero_o`=0. BEQ A=7, B=7 → result 0, `Zero_o`=1.
- MUL A=0xFFFFFFFF, B=3 → cycle 34: result 0xFFFFFFFD. MULH with the same operands → 0xFFFFFFFF.
- DIV A=-7, B=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. Both at cycle 34, with `ready_o`=0 in cycles 1..33.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/-1 → 0x80000000; REM → 0.
  - All at latency 34.
- Back-to-back and ignored requests:
  - ADD, XOR, SLLI(A=1, B=35 → shamt 3 → 8) on consecutive cycles give three consecutive `valid_o` pulses.
  - `valid_i` held high during a DIV is ignored until cycle 34.
- `reset` asserted in cycle 10 of a DIV → cycle 11: `ready_o`=1, `valid_o`=0, result 0, with no later `valid_o` pulse.
